// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: hazard priority, LSU wait and post-trap flush window.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int unsigned TRAP_FLUSH_CYCLES = 1,
    parameter int unsigned PERF_WIDTH        = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hdu_load_stall,
    input  logic       ex_redirect,
    input  logic       mem_trap,
    input  logic       mem_mret,
    input  logic       lsu_busy,
    output logic       if_stall,
    output logic       id_stall,
    output logic       id_flush,
    output logic       ex_stall,
    output logic       ex_flush,
    output logic       mem_stall,
    output logic       mem_flush,
    output logic       if_flush,
    output logic [1:0] pc_sel,
    output logic       trap_taken
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_WIDTH-1:0] perf_flush_events,
    output logic [PERF_WIDTH-1:0] perf_trap_events
`endif
);

    typedef enum logic [1:0] {
        RUN,
        LSU_WAIT,
        TRAP_FLUSH
    } state_t;

    localparam logic [3:0] FLUSH_INIT = 4'(TRAP_FLUSH_CYCLES);

    if (TRAP_FLUSH_CYCLES > 15 || PERF_WIDTH == 0) begin : g_bad_params
        $error("pipeline_ctrl: parameter out of range");
    end

    state_t     r_state;
    state_t     w_state_eff;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;

    // While rst is high the stored state is ignored so only live inputs reach the outputs.
    assign w_state_eff = rst ? RUN : r_state;

    always_comb begin
        if_stall     = 1'b0;
        id_stall     = 1'b0;
        id_flush     = 1'b0;
        ex_stall     = 1'b0;
        ex_flush     = 1'b0;
        mem_stall    = 1'b0;
        mem_flush    = 1'b0;
        if_flush     = 1'b0;
        pc_sel       = 2'd0;
        trap_taken   = 1'b0;
        w_next_state = RUN;
        w_next_cnt   = r_cnt;

        case (w_state_eff)
            TRAP_FLUSH: begin
                id_flush = 1'b1;
                ex_flush = 1'b1;
                if (r_cnt <= 4'd1) begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_state = TRAP_FLUSH;
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            // LSU_WAIT shares RUN's priority: a busy cycle repeats the stall, release re-evaluates.
            default: begin
                if (mem_trap || mem_mret) begin
                    if_flush   = 1'b1;
                    id_flush   = 1'b1;
                    ex_flush   = 1'b1;
                    mem_flush  = 1'b1;
                    trap_taken = 1'b1;
                    pc_sel     = mem_trap ? 2'd2 : 2'd3;
                    if (FLUSH_INIT != 4'd0) begin
                        w_next_state = TRAP_FLUSH;
                        w_next_cnt   = FLUSH_INIT;
                    end else begin
                        w_next_cnt   = '0;
                    end
                end else if (lsu_busy) begin
                    if_stall     = 1'b1;
                    id_stall     = 1'b1;
                    ex_stall     = 1'b1;
                    mem_stall    = 1'b1;
                    mem_flush    = 1'b1;
                    w_next_state = LSU_WAIT;
                end else if (ex_redirect) begin
                    if_flush = 1'b1;
                    id_flush = 1'b1;
                    pc_sel   = 2'd1;
                end else if (hdu_load_stall) begin
                    if_stall = 1'b1;
                    id_stall = 1'b1;
                    id_flush = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [PERF_WIDTH-1:0] r_perf_stall;
    logic [PERF_WIDTH-1:0] r_perf_flush;
    logic [PERF_WIDTH-1:0] r_perf_trap;

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_trap  <= '0;
        end else begin
            if (if_stall && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + PERF_WIDTH'(1);
            if (if_flush && r_perf_flush != '1)
                r_perf_flush <= r_perf_flush + PERF_WIDTH'(1);
            if (trap_taken && r_perf_trap != '1)
                r_perf_trap <= r_perf_trap + PERF_WIDTH'(1);
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_flush_events = r_perf_flush;
    assign perf_trap_events  = r_perf_trap;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed table-driven bench for pipeline_ctrl with TRAP_FLUSH_CYCLES=2.
module tb_pipeline_ctrl;

    logic       clk;
    logic       rst;
    logic       hdu_load_stall;
    logic       ex_redirect;
    logic       mem_trap;
    logic       mem_mret;
    logic       lsu_busy;
    logic       if_stall;
    logic       id_stall;
    logic       id_flush;
    logic       ex_stall;
    logic       ex_flush;
    logic       mem_stall;
    logic       mem_flush;
    logic       if_flush;
    logic [1:0] pc_sel;
    logic       trap_taken;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_events;
    logic [31:0] perf_trap_events;
`endif

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    pipeline_ctrl #(
        .TRAP_FLUSH_CYCLES(2),
        .PERF_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hdu_load_stall(hdu_load_stall),
        .ex_redirect(ex_redirect),
        .mem_trap(mem_trap),
        .mem_mret(mem_mret),
        .lsu_busy(lsu_busy),
        .if_stall(if_stall),
        .id_stall(id_stall),
        .id_flush(id_flush),
        .ex_stall(ex_stall),
        .ex_flush(ex_flush),
        .mem_stall(mem_stall),
        .mem_flush(mem_flush),
        .if_flush(if_flush),
        .pc_sel(pc_sel),
        .trap_taken(trap_taken)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_events(perf_flush_events),
        .perf_trap_events(perf_trap_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output vector: {if_stall,id_stall,id_flush,ex_stall,ex_flush,mem_stall,mem_flush,if_flush,pc_sel[1:0],trap_taken}
    localparam logic [10:0] O_IDLE = 11'b00000000000;
    localparam logic [10:0] O_LOAD = 11'b11100000000;
    localparam logic [10:0] O_BRCH = 11'b00100001010;
    localparam logic [10:0] O_LSU  = 11'b11010110000;
    localparam logic [10:0] O_TRAP = 11'b00101011101;
    localparam logic [10:0] O_MRET = 11'b00101011111;
    localparam logic [10:0] O_TFL  = 11'b00101000000;

    // Input vector: {rst,hdu_load_stall,ex_redirect,mem_trap,mem_mret,lsu_busy}
    typedef struct {
        logic [5:0]  in;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] outs();
        return {if_stall, id_stall, id_flush, ex_stall, ex_flush, mem_stall,
                mem_flush, if_flush, pc_sel, trap_taken};
    endfunction

    task automatic drive(input logic [5:0] in);
        {rst, hdu_load_stall, ex_redirect, mem_trap, mem_mret, lsu_busy} = in;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 ns later, well before the next rising edge.
    task automatic step(input logic [5:0] in, input logic [10:0] exp, input string name);
        logic [10:0] act;
        @(negedge clk);
        drive(in);
        #1;
        act = outs();
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check32(input logic [31:0] act, input logic [31:0] exp, input string name);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] in, input logic [10:0] exp, input string name);
        vec_t v;
        v.in   = in;
        v.exp  = exp;
        v.name = name;
        vecs.push_back(v);
    endtask

    initial begin
        drive(6'b100000);

        add(6'b100000, O_IDLE, "reset_idle");
        add(6'b110000, O_LOAD, "reset_with_load_input");
        add(6'b000000, O_IDLE, "post_reset_idle");
        add(6'b010000, O_LOAD, "load_use");
        add(6'b000000, O_IDLE, "load_use_release");
        add(6'b011000, O_BRCH, "branch_masks_load");
        add(6'b001000, O_BRCH, "branch_alone");
        add(6'b001001, O_LSU,  "lsu_busy_1");
        add(6'b001001, O_LSU,  "lsu_busy_2");
        add(6'b001001, O_LSU,  "lsu_busy_3");
        add(6'b001000, O_BRCH, "lsu_release_branch");
        add(6'b000000, O_IDLE, "idle_a");
        add(6'b000100, O_TRAP, "trap");
        add(6'b000000, O_TFL,  "trap_flush_1");
        add(6'b000100, O_TFL,  "trap_flush_2_trap_ignored");
        add(6'b000000, O_IDLE, "trap_window_done");
        add(6'b000110, O_TRAP, "trap_and_mret");
        add(6'b000000, O_TFL,  "tm_flush_1");
        add(6'b000000, O_TFL,  "tm_flush_2");
        add(6'b000000, O_IDLE, "tm_done");
        add(6'b000010, O_MRET, "mret");
        add(6'b000000, O_TFL,  "mret_flush_1");
        add(6'b000000, O_TFL,  "mret_flush_2");
        add(6'b000000, O_IDLE, "mret_done");
        add(6'b000101, O_TRAP, "trap_over_lsu");
        add(6'b000000, O_TFL,  "tl_flush_1");
        add(6'b000000, O_TFL,  "tl_flush_2");
        add(6'b000000, O_IDLE, "tl_done");
        add(6'b000001, O_LSU,  "lsu_enter");
        add(6'b100000, O_IDLE, "reset_in_lsu_wait");
        add(6'b010000, O_LOAD, "load_after_reset");
        add(6'b000000, O_IDLE, "idle_b");
        add(6'b000001, O_LSU,  "lsu_enter_2");
        add(6'b000101, O_TRAP, "trap_in_lsu_wait");
        add(6'b000000, O_TFL,  "tlw_flush_1");
        add(6'b000000, O_TFL,  "tlw_flush_2");
        add(6'b000000, O_IDLE, "tlw_done");
        add(6'b000100, O_TRAP, "trap_before_reset");
        add(6'b100000, O_IDLE, "reset_in_trap_flush");
        add(6'b000000, O_IDLE, "after_reset_in_trap_flush");
        add(6'b010001, O_LSU,  "lsu_masks_load");
        add(6'b010000, O_LOAD, "lsu_release_load");
        add(6'b000000, O_IDLE, "idle_c");

        foreach (vecs[i]) step(vecs[i].in, vecs[i].exp, vecs[i].name);

        // Counter scenario: 5 load-use stall cycles then 2 redirects from a fresh reset.
        step(6'b100000, O_IDLE, "perf_reset");
        for (int i = 0; i < 5; i++) step(6'b010000, O_LOAD, "perf_load");
        for (int i = 0; i < 2; i++) step(6'b001000, O_BRCH, "perf_branch");
        step(6'b000000, O_IDLE, "perf_idle");
`ifdef PIPE_CTRL_PERF_EN
        check32(perf_stall_cycles, 32'd5, "perf_stall_cycles");
        check32(perf_flush_events, 32'd2, "perf_flush_events");
        check32(perf_trap_events,  32'd0, "perf_trap_events");
        step(6'b000100, O_TRAP, "perf_trap");
        step(6'b000000, O_TFL,  "perf_trap_flush");
        check32(perf_trap_events,  32'd1, "perf_trap_events_after");
        check32(perf_flush_events, 32'd3, "perf_flush_events_after");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
